// File: rtl/register_file_mp_pkg.sv
// Shared constants and helpers for the multi-port register file and the
// decode/hazard logic that slices its flattened port buses.
package register_file_mp_pkg;

   localparam int RF_XLEN  = 32;
   localparam int RF_NREGS = 32;
   localparam int RF_AW    = $clog2(RF_NREGS);
   localparam int RF_REG0  = 0;

   // A register accepts writes and issues unless it is the hardwired zero register.
   function automatic logic rf_writable(input logic addr_is_reg0, input logic zero_reg);
      return !(zero_reg && addr_is_reg0);
   endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Decode/writeback bus of the register file: read ports, write ports, issue
// port and the sticky write-conflict flag, all flattened per port.
interface register_file_mp_if
   import register_file_mp_pkg::*;
#(
   parameter int XLEN  = RF_XLEN,
   parameter int NREGS = RF_NREGS,
   parameter int NRD   = 2,
   parameter int NWR   = 2
);
   localparam int AW = $clog2(NREGS);

   logic [NRD*AW-1:0]   read_addr;
   logic [NRD*XLEN-1:0] read_data;
   logic [NRD-1:0]      read_busy;
   logic [NWR-1:0]      write_enable;
   logic [NWR*AW-1:0]   write_addr;
   logic [NWR*XLEN-1:0] write_data;
   logic                issue_enable;
   logic [AW-1:0]       issue_addr;
   logic                wr_conflict;

   modport master (
      output read_addr, write_enable, write_addr, write_data, issue_enable, issue_addr,
      input  read_data, read_busy, wr_conflict
   );

   modport slave (
      input  read_addr, write_enable, write_addr, write_data, issue_enable, issue_addr,
      output read_data, read_busy, wr_conflict
   );

endinterface

// File: rtl/register_file_mp_read_port.sv
// One combinational read port: zero-register check, same-cycle write bypass
// (highest write port wins) and busy forwarding.
module register_file_mp_read_port
   import register_file_mp_pkg::*;
#(
   parameter int XLEN     = RF_XLEN,
   parameter int AW       = RF_AW,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                i_reset,
   input  logic [AW-1:0]       i_addr,
   input  logic [XLEN-1:0]     i_word,
   input  logic                i_busy,
   input  logic [NWR-1:0]      i_wr_en,
   input  logic [NWR*AW-1:0]   i_wr_addr,
   input  logic [NWR*XLEN-1:0] i_wr_data,
   output logic [XLEN-1:0]     o_data,
   output logic                o_busy
);

   logic            w_hit;
   logic [XLEN-1:0] w_byp;
   logic            w_is_zero;

   // Ascending scan so the highest-indexed matching write port overrides.
   always_comb begin
      w_hit = 1'b0;
      w_byp = '0;
      for (int j = 0; j < NWR; j++) begin
         if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] == i_addr)) begin
            w_hit = 1'b1;
            w_byp = i_wr_data[j*XLEN +: XLEN];
         end
      end
   end

   assign w_is_zero = (ZERO_REG != 0) && (i_addr == AW'(RF_REG0));

   // Reset suppresses forwarding so readers see the array as it is being cleared.
   always_comb begin
      o_data = i_word;
      o_busy = i_busy;
      if (w_is_zero) begin
         o_data = '0;
         o_busy = 1'b0;
      end else if (!i_reset && w_hit) begin
         o_data = w_byp;
         o_busy = 1'b0;
      end
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with busy scoreboard: storage array, write priority,
// issue/writeback busy tracking and a sticky same-register write-conflict flag.
module register_file_mp
   import register_file_mp_pkg::*;
#(
   parameter int XLEN     = RF_XLEN,
   parameter int NREGS    = RF_NREGS,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic               clk,
   input  logic               reset,
   register_file_mp_if.slave  bus
);

   localparam int   AW = $clog2(NREGS);
   localparam logic ZR = (ZERO_REG != 0);

   logic [XLEN-1:0]  r_regs [NREGS];
   logic [NREGS-1:0] r_busy;
   logic             r_conflict;

   logic [NWR-1:0]   w_wr_ok;
   logic [NREGS-1:0] w_wb_hit;
   logic             w_issue_ok;
   logic             w_conflict_now;

   genvar gi;

   generate
      for (gi = 0; gi < NWR; gi++) begin : g_wr_ok
         assign w_wr_ok[gi] = bus.write_enable[gi] &&
            rf_writable(bus.write_addr[gi*AW +: AW] == AW'(RF_REG0), ZR);
      end
   endgenerate

   assign w_issue_ok = bus.issue_enable && rf_writable(bus.issue_addr == AW'(RF_REG0), ZR);

   always_comb begin
      w_wb_hit = '0;
      for (int j = 0; j < NWR; j++) begin
         if (w_wr_ok[j]) begin
            w_wb_hit[bus.write_addr[j*AW +: AW]] = 1'b1;
         end
      end
   end

   // Any pair of accepted writes to one register is a conflict; dropped reg-0 writes never count.
   always_comb begin
      w_conflict_now = 1'b0;
      for (int j = 0; j < NWR; j++) begin
         for (int k = j + 1; k < NWR; k++) begin
            if (w_wr_ok[j] && w_wr_ok[k] &&
                (bus.write_addr[j*AW +: AW] == bus.write_addr[k*AW +: AW])) begin
               w_conflict_now = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NREGS; k++) begin
            r_regs[k] <= '0;
         end
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (w_wr_ok[j]) begin
               r_regs[bus.write_addr[j*AW +: AW]] <= bus.write_data[j*XLEN +: XLEN];
            end
         end
      end
   end

   // Issue outranks a same-cycle writeback so a reissued destination stays busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if (w_issue_ok && (bus.issue_addr == AW'(r))) begin
               r_busy[r] <= 1'b1;
            end else if (w_wb_hit[r]) begin
               r_busy[r] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_conflict <= 1'b0;
      end else if (w_conflict_now) begin
         r_conflict <= 1'b1;
      end
   end

   assign bus.wr_conflict = r_conflict;

   generate
      for (gi = 0; gi < NRD; gi++) begin : g_rd
         logic [AW-1:0]   w_rd_addr;
         logic [XLEN-1:0] w_rd_data;
         logic            w_rd_busy;

         assign w_rd_addr = bus.read_addr[gi*AW +: AW];

         register_file_mp_read_port #(
            .XLEN     (XLEN),
            .AW       (AW),
            .NWR      (NWR),
            .ZERO_REG (ZERO_REG)
         ) u_port (
            .i_reset   (reset),
            .i_addr    (w_rd_addr),
            .i_word    (r_regs[w_rd_addr]),
            .i_busy    (r_busy[w_rd_addr]),
            .i_wr_en   (bus.write_enable),
            .i_wr_addr (bus.write_addr),
            .i_wr_data (bus.write_data),
            .o_data    (w_rd_data),
            .o_busy    (w_rd_busy)
         );

         assign bus.read_data[gi*XLEN +: XLEN] = w_rd_data;
         assign bus.read_busy[gi]              = w_rd_busy;
      end
   endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// Randomized bench for register_file_mp: two instances (ZERO_REG=1 and 0) share
// stimulus and are checked each cycle against an array-based reference model.
module tb_register_file_mp;
   import register_file_mp_pkg::*;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = $clog2(NREGS);

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [AW-1:0]   ra [NRD];
   logic [NWR-1:0]  we;
   logic [AW-1:0]   wa [NWR];
   logic [XLEN-1:0] wd [NWR];
   logic            ie;
   logic [AW-1:0]   ia;

   register_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus_z ();
   register_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus_n ();

   register_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) u_dut_z (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_z)
   );

   register_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(0)) u_dut_n (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_n)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NRD; gi++) begin : g_drv_rd
         assign bus_z.read_addr[gi*AW +: AW] = ra[gi];
         assign bus_n.read_addr[gi*AW +: AW] = ra[gi];
      end
      for (gi = 0; gi < NWR; gi++) begin : g_drv_wr
         assign bus_z.write_addr[gi*AW +: AW]     = wa[gi];
         assign bus_n.write_addr[gi*AW +: AW]     = wa[gi];
         assign bus_z.write_data[gi*XLEN +: XLEN] = wd[gi];
         assign bus_n.write_data[gi*XLEN +: XLEN] = wd[gi];
      end
   endgenerate
   assign bus_z.write_enable = we;
   assign bus_n.write_enable = we;
   assign bus_z.issue_enable = ie;
   assign bus_n.issue_enable = ie;
   assign bus_z.issue_addr   = ia;
   assign bus_n.issue_addr   = ia;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   // Reference model: index 1 = ZERO_REG instance, index 0 = ordinary instance.
   logic [XLEN-1:0] m_regs [2][NREGS];
   bit              m_busy [2][NREGS];
   bit              m_conf [2];

   function automatic bit dropped(input int z, input logic [AW-1:0] a);
      return (z == 1) && (a == 0);
   endfunction

   function automatic logic [XLEN-1:0] exp_data(input int z, input int i);
      logic [AW-1:0] a = ra[i];
      if (dropped(z, a)) return '0;
      if (!reset)
         for (int j = NWR - 1; j >= 0; j--)
            if (we[j] && wa[j] == a) return wd[j];
      return m_regs[z][a];
   endfunction

   function automatic logic exp_busy(input int z, input int i);
      logic [AW-1:0] a = ra[i];
      if (dropped(z, a)) return 1'b0;
      for (int j = 0; j < NWR; j++)
         if (we[j] && wa[j] == a) return 1'b0;
      return m_busy[z][a];
   endfunction

   function automatic logic [XLEN-1:0] got_data(input int z, input int i);
      return (z == 1) ? bus_z.read_data[i*XLEN +: XLEN] : bus_n.read_data[i*XLEN +: XLEN];
   endfunction

   function automatic logic got_busy(input int z, input int i);
      return (z == 1) ? bus_z.read_busy[i] : bus_n.read_busy[i];
   endfunction

   function automatic logic got_conf(input int z);
      return (z == 1) ? bus_z.wr_conflict : bus_n.wr_conflict;
   endfunction

   always @(posedge clk) begin
      for (int z = 0; z < 2; z++) begin
         if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
               m_regs[z][r] <= '0;
               m_busy[z][r] <= 1'b0;
            end
            m_conf[z] <= 1'b0;
         end else begin
            for (int j = 0; j < NWR; j++) begin
               if (we[j] && !dropped(z, wa[j])) begin
                  m_regs[z][wa[j]] <= wd[j];
                  m_busy[z][wa[j]] <= 1'b0;
               end
            end
            if (ie && !dropped(z, ia)) m_busy[z][ia] <= 1'b1;
            for (int j = 0; j < NWR; j++)
               for (int k = j + 1; k < NWR; k++)
                  if (we[j] && we[k] && wa[j] == wa[k] && !dropped(z, wa[j])) m_conf[z] <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < NRD; i++) begin
               check($sformatf("model z%0d rd%0d data", z, i), got_data(z, i), exp_data(z, i));
               if (!reset)
                  check($sformatf("model z%0d rd%0d busy", z, i), XLEN'(got_busy(z, i)), XLEN'(exp_busy(z, i)));
            end
            check($sformatf("model z%0d wr_conflict", z), XLEN'(got_conf(z)), XLEN'(m_conf[z]));
         end
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = '0;
      ie = 1'b0;
      ia = '0;
      for (int j = 0; j < NWR; j++) begin
         wa[j] = '0;
         wd[j] = '0;
      end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      for (int i = 0; i < NRD; i++) ra[i] = '0;
      next();
      next();
      reset  = 1'b0;
      cmp_en = 1'b1;
      @(negedge clk);
      check("reset conflict z", XLEN'(bus_z.wr_conflict), '0);
      check("reset data n r0", bus_n.read_data[0 +: XLEN], '0);
      $display("reset released");

      next();
      we[0] = 1'b1; wa[0] = 5'd1; wd[0] = 32'h12345678;
      next();
      idle(); ra[0] = 5'd1;
      @(negedge clk);
      check("t1 data", got_data(1, 0), 32'h12345678);
      check("t1 busy", XLEN'(got_busy(1, 0)), '0);
      $display("t1 write r1 then read: %h", got_data(1, 0));

      next();
      we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hDEADBEEF;
      next();
      idle(); ra[0] = 5'd0;
      @(negedge clk);
      check("t2 zero_reg=1 r0", got_data(1, 0), '0);
      check("t2 zero_reg=0 r0", got_data(0, 0), 32'hDEADBEEF);
      $display("t2 r0 reads: z=%h n=%h", got_data(1, 0), got_data(0, 0));

      next();
      we = 2'b11; wa[0] = 5'd2; wa[1] = 5'd2; wd[0] = 32'h11111111; wd[1] = 32'hABCDEF01; ra[0] = 5'd2;
      @(negedge clk);
      check("t3 bypass", got_data(1, 0), 32'hABCDEF01);
      next();
      idle();
      @(negedge clk);
      check("t3 array", got_data(1, 0), 32'hABCDEF01);
      check("t3 conflict z", XLEN'(bus_z.wr_conflict), 32'd1);
      check("t3 conflict n", XLEN'(bus_n.wr_conflict), 32'd1);
      $display("t3 dual write r2: %h conflict=%0b", got_data(1, 0), bus_z.wr_conflict);

      next();
      ie = 1'b1; ia = 5'd5;
      next();
      idle(); ra[0] = 5'd5;
      @(negedge clk);
      check("t4 busy after issue", XLEN'(got_busy(1, 0)), 32'd1);
      next();
      we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hCAFEBABE;
      @(negedge clk);
      check("t4 busy on wb", XLEN'(got_busy(1, 0)), '0);
      check("t4 data on wb", got_data(1, 0), 32'hCAFEBABE);
      next();
      idle();
      @(negedge clk);
      check("t4 busy after wb", XLEN'(got_busy(1, 0)), '0);
      check("t4 conflict sticky", XLEN'(bus_z.wr_conflict), 32'd1);
      $display("t4 issue/writeback r5: %h", got_data(1, 0));

      next();
      ie = 1'b1; ia = 5'd7; we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h5;
      next();
      idle(); ra[0] = 5'd7;
      @(negedge clk);
      check("t5 issue wins busy", XLEN'(got_busy(1, 0)), 32'd1);
      check("t5 data", got_data(1, 0), 32'h5);
      $display("t5 issue+wb r7: busy=%0b data=%h", got_busy(1, 0), got_data(1, 0));

      for (int r = 1; r < NREGS; r += 2) begin
         next();
         idle();
         we[0] = 1'b1; wa[0] = AW'(r); wd[0] = XLEN'(32'h100 + r);
         if (r + 1 < NREGS) begin
            we[1] = 1'b1; wa[1] = AW'(r + 1); wd[1] = XLEN'(32'h100 + r + 1);
         end
      end
      next();
      idle(); ie = 1'b1; ia = 5'd3;
      next();
      idle(); ra[0] = 5'd31; ra[1] = 5'd3;
      @(negedge clk);
      check("t6 r31", got_data(1, 0), 32'h11F);
      check("t6 r3 data", got_data(1, 1), 32'h103);
      check("t6 r3 busy", XLEN'(got_busy(1, 1)), 32'd1);
      next();
      reset = 1'b1; we[0] = 1'b1; wa[0] = 5'd4; wd[0] = 32'hFFFF;
      next();
      reset = 1'b0; idle();
      for (int r = 0; r < NREGS; r++) begin
         ra[0] = AW'(r); ra[1] = AW'(NREGS - 1 - r);
         @(negedge clk);
         check($sformatf("t6 post-reset r%0d", r), got_data(0, 0), '0);
         check($sformatf("t6 post-reset busy r%0d", r), XLEN'(got_busy(0, 0)), '0);
         next();
      end
      check("t6 conflict cleared", XLEN'(bus_z.wr_conflict), '0);
      $display("t6 fill/issue/reset done");

      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         ie = ($urandom_range(0, 2) == 0);
         ia = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS - 1));
         for (int j = 0; j < NWR; j++) begin
            we[j] = ($urandom_range(0, 1) != 0);
            wa[j] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS - 1));
            wd[j] = $urandom;
         end
         for (int i = 0; i < NRD; i++)
            ra[i] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS - 1));
         next();
      end
      reset = 1'b0;
      idle();
      next();
      @(negedge clk);
      cmp_en = 1'b0;
      $display("random phase done");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
